gcd_req_ctrl: RTL and testbench

- Initiator-side controller for the GCD core.
- Accepts operand pairs from an upstream valid/ready source, issues each pair to the core with a one-cycle start pulse, and waits for the core's done.
- Returns the result downstream on a valid/ready output with an error flag.
- Adds a zero-operand bypass and a watchdog timeout, so software-level users never drive start/done directly.

---
 rtl/gcd_req_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_gcd_req_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_req_ctrl.sv
// -----------------------------------------------------------------------------
// gcd_req_ctrl
//
// Initiator-side controller for a GCD core. An operand pair arrives on a
// valid/ready input. It is either answered directly (either operand zero) or
// handed to the core with a single-cycle start pulse. The controller then
// waits for the core's done, guarded by a watchdog. The result leaves on a
// valid/ready output together with an error flag that marks a timeout.
//
// Optional build macro: GCD_STATS_EN adds the statistics outputs
// stat_ops, stat_err and stat_last_lat.
//
// Parameters:
//   OP_SZ        operand / result width
//   TIMEOUT_CYC  maximum WAIT cycles before a timeout result (>= 2)
//   TO_W         watchdog counter width (2**TO_W > TIMEOUT_CYC)
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake; in_a, in_b operands
//   core_a, core_b     operands presented to the core (stable while busy)
//   core_start         one-cycle start pulse to the core
//   core_done/core_res completion level and result from the core
//   out_valid/out_ready result handshake; out_res result, out_err timeout flag
//   stat_ops, stat_err, stat_last_lat (GCD_STATS_EN only)
//                      completed results, timeouts and last WAIT cycle count
// -----------------------------------------------------------------------------
module gcd_req_ctrl #(
  parameter int OP_SZ       = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_SZ-1:0] in_a,
  input  logic [OP_SZ-1:0] in_b,
  output logic [OP_SZ-1:0] core_a,
  output logic [OP_SZ-1:0] core_b,
  output logic             core_start,
  input  logic             core_done,
  input  logic [OP_SZ-1:0] core_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_SZ-1:0] out_res,
  output logic             out_err
`ifdef GCD_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [7:0]       stat_err,
  output logic [TO_W-1:0]  stat_last_lat
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Last counter value that may still be reached without declaring a timeout.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_FULL = TO_W'(TIMEOUT_CYC);

  state_t           state_r;
  state_t           state_nx_s;
  logic             in_ready_r;
  logic             core_start_r;
  logic             out_valid_r;
  logic [OP_SZ-1:0] op_a_r;
  logic [OP_SZ-1:0] op_b_r;
  logic [OP_SZ-1:0] res_r;
  logic             err_r;
  logic [TO_W-1:0]  cnt_r;

  logic             accept_s;
  logic             bypass_s;
  logic             done_hit_s;
  logic             to_hit_s;
  logic             resp_hs_s;

  // Next-state decode and the one-cycle event strobes used by the datapath.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    bypass_s   = 1'b0;
    done_hit_s = 1'b0;
    to_hit_s   = 1'b0;
    resp_hs_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // in_ready_r is only high in IDLE, but gating on it keeps the
        // first cycle after reset release consistent with the port.
        if (in_valid && in_ready_r) begin
          accept_s = 1'b1;
          if ((in_a == {OP_SZ{1'b0}}) || (in_b == {OP_SZ{1'b0}})) begin
            bypass_s   = 1'b1;
            state_nx_s = ST_RESP;
          end else begin
            state_nx_s = ST_ISSUE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // core_done is not looked at here: the core may still show the
        // previous operation's level during the start cycle.
        state_nx_s = ST_WAIT;
      end
      ST_WAIT: begin
        // done takes priority over a watchdog expiry in the same cycle.
        if (core_done) begin
          done_hit_s = 1'b1;
          state_nx_s = ST_RESP;
        end else if (cnt_r == TO_LAST) begin
          to_hit_s   = 1'b1;
          state_nx_s = ST_RESP;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (out_valid_r && out_ready) begin
          resp_hs_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register plus handshake/strobe outputs registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      in_ready_r   <= 1'b0;
      core_start_r <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      in_ready_r   <= (state_nx_s == ST_IDLE);
      core_start_r <= (state_nx_s == ST_ISSUE);
      out_valid_r  <= (state_nx_s == ST_RESP);
    end
  end

  // Operand registers feeding the core; loaded only on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a_r <= {OP_SZ{1'b0}};
      op_b_r <= {OP_SZ{1'b0}};
    end else if (accept_s) begin
      op_a_r <= in_a;
      op_b_r <= in_b;
    end
  end

  // Result and error flag; held untouched for the whole RESP phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_r <= {OP_SZ{1'b0}};
      err_r <= 1'b0;
    end else if (bypass_s) begin
      // gcd(x,0) = x and gcd(0,0) = 0, so OR-ing the operands is exact.
      res_r <= in_a | in_b;
      err_r <= 1'b0;
    end else if (done_hit_s) begin
      res_r <= core_res;
      err_r <= 1'b0;
    end else if (to_hit_s) begin
      res_r <= {OP_SZ{1'b0}};
      err_r <= 1'b1;
    end
  end

  // Watchdog counter: cleared during the start cycle, counts WAIT cycles without done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {TO_W{1'b0}};
    end else if (state_r == ST_ISSUE) begin
      cnt_r <= {TO_W{1'b0}};
    end else if ((state_r == ST_WAIT) && !done_hit_s && !to_hit_s) begin
      cnt_r <= cnt_r + TO_W'(1);
    end
  end

`ifdef GCD_STATS_EN
  logic [15:0]     stat_ops_r;
  logic [7:0]      stat_err_r;
  logic [TO_W-1:0] stat_lat_r;

  // Saturating counters of delivered results and of timeouts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ops_r <= 16'd0;
      stat_err_r <= 8'd0;
    end else begin
      if (resp_hs_s && (stat_ops_r != 16'hFFFF)) begin
        stat_ops_r <= stat_ops_r + 16'd1;
      end
      if (to_hit_s && (stat_err_r != 8'hFF)) begin
        stat_err_r <= stat_err_r + 8'd1;
      end
    end
  end

  // WAIT cycles spent by the most recent operation (the current cycle included).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_lat_r <= {TO_W{1'b0}};
    end else if (bypass_s) begin
      stat_lat_r <= {TO_W{1'b0}};
    end else if (done_hit_s) begin
      stat_lat_r <= cnt_r + TO_W'(1);
    end else if (to_hit_s) begin
      stat_lat_r <= TO_FULL;
    end
  end

  assign stat_ops      = stat_ops_r;
  assign stat_err      = stat_err_r;
  assign stat_last_lat = stat_lat_r;
`else
  // Without statistics the handshake strobe and full-count constant have no consumer.
  logic unused_s;
  assign unused_s = resp_hs_s ^ (^TO_FULL);
`endif

  assign in_ready   = in_ready_r;
  assign core_start = core_start_r;
  assign core_a     = op_a_r;
  assign core_b     = op_b_r;
  assign out_valid  = out_valid_r;
  assign out_res    = res_r;
  assign out_err    = err_r;

endmodule

// File: tb/tb_gcd_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gcd_req_ctrl
//
// Scoreboard bench for gcd_req_ctrl. The driver pushes the expected response
// (result, error flag, and cycles from acceptance to out_valid) for each
// pair it issues. A monitor compares whatever the DUT presents. A behavioural
// core model answers core_start after a chosen number of WAIT cycles, or
// never answers (delay 0). The watchdog is shortened to 16 cycles.
// -----------------------------------------------------------------------------
module tb_gcd_req_ctrl;

  localparam int OP_SZ  = 8;
  localparam int TO_CYC = 16;
  localparam int TO_W   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OP_SZ-1:0] in_a = '0;
  logic [OP_SZ-1:0] in_b = '0;
  logic [OP_SZ-1:0] core_a;
  logic [OP_SZ-1:0] core_b;
  logic             core_start;
  logic             core_done;
  logic [OP_SZ-1:0] core_res;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OP_SZ-1:0] out_res;
  logic             out_err;
`ifdef GCD_STATS_EN
  logic [15:0]      stat_ops;
  logic [7:0]       stat_err;
  logic [TO_W-1:0]  stat_last_lat;
`endif

  gcd_req_ctrl #(.OP_SZ(OP_SZ), .TIMEOUT_CYC(TO_CYC), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_a(core_a), .core_b(core_b), .core_start(core_start),
    .core_done(core_done), .core_res(core_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_err(out_err)
`ifdef GCD_STATS_EN
    , .stat_ops(stat_ops), .stat_err(stat_err), .stat_last_lat(stat_last_lat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       err;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cur_dly = 0;
  int   exp_starts = 0;
  int   starts = 0;
  int   hs_cnt = 0;
  int   to_cnt = 0;
  logic rdy_rand = 1'b0;
  logic rdy_fix  = 1'b1;
  int   rem = 0;

  function automatic int gcd_ref(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Core model: done is raised in the k-th WAIT cycle (k = cur_dly), never if k = 0.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem       <= 0;
      core_done <= 1'b0;
      core_res  <= '0;
    end else if (core_start) begin
      rem       <= (cur_dly == 0) ? 0 : cur_dly - 1;
      core_done <= (cur_dly == 1);
      core_res  <= 8'(gcd_ref(int'(core_a), int'(core_b)));
    end else if (rem > 0) begin
      rem       <= rem - 1;
      core_done <= (rem == 1);
    end else begin
      core_done <= 1'b0;
    end
  end

  // Downstream ready: fixed or random, changed 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  task automatic monitor();
    logic pend = 1'b0, hs_prev = 1'b0, cs_prev = 1'b0, flight = 1'b0;
    logic [7:0] hres = '0;
    logic herr = 1'b0;
    int t = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend = 1'b0; hs_prev = 1'b0; cs_prev = 1'b0; flight = 1'b0;
        t = 0; hs_cnt = 0; to_cnt = 0;
      end else begin
        t++;
        if (hs_prev) chk("valid_one_cycle", 32'(out_valid), 32'd0);
        if (core_start) begin
          starts++;
          chk("start_single_pulse", 32'(cs_prev), 32'd0);
          flight = 1'b1;
        end
        if (flight && exp_q.size() != 0) begin
          chk("core_a", 32'(core_a), 32'(exp_q[0].a));
          chk("core_b", 32'(core_b), 32'(exp_q[0].b));
        end
        if (out_valid) begin
          flight = 1'b0;
          chk("in_ready_low_in_resp", 32'(in_ready), 32'd0);
          if (!pend) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_result: got out_valid res=%0d, required no result", out_res);
            end else begin
              chk("latency", 32'(t), 32'(exp_q[0].lat));
            end
          end else begin
            chk("hold_res", 32'(out_res), 32'(hres));
            chk("hold_err", 32'(out_err), 32'(herr));
          end
          hres = out_res;
          herr = out_err;
          if (out_ready && exp_q.size() != 0) begin
            chk("out_res", 32'(out_res), 32'(exp_q[0].res));
            chk("out_err", 32'(out_err), 32'(exp_q[0].err));
            if (exp_q[0].err) to_cnt++;
            hs_cnt++;
            void'(exp_q.pop_front());
          end
        end
        pend    = out_valid && !out_ready;
        hs_prev = out_valid && out_ready;
        cs_prev = core_start;
        if (in_valid && in_ready) t = 0;
      end
    end
  endtask

  task automatic send(input int a, input int b, input int k);
    int n = 0;
    exp_t e;
    while (!in_ready && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_wait: in_ready=0 after %0d cycles, required 1", n);
      return;
    end
    e.a = 8'(a);
    e.b = 8'(b);
    if (a == 0 || b == 0) begin
      e.res = 8'(a | b); e.err = 1'b0; e.lat = 1;
    end else begin
      exp_starts++;
      if (k == 0 || k > TO_CYC) begin
        e.res = 8'd0; e.err = 1'b1; e.lat = TO_CYC + 2;
      end else begin
        e.res = 8'(gcd_ref(a, b)); e.err = 1'b0; e.lat = k + 2;
      end
    end
    exp_q.push_back(e);
    cur_dly  = k;
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL result_wait: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    int a, b, k, n;
    fork
      monitor();
    join_none

    // Reset state.
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_res", 32'(out_res), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_core_ab", 32'({core_a, core_b}), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Directed cases.
    send(25, 15, 6);                    wait_idle();
    send(12, 9, 3);  send(12, 8, 5);    wait_idle();
    send(0, 7, 0);   send(0, 0, 0);     wait_idle();
    send(200, 0, 0);                    wait_idle();
    send(20, 30, 0); send(12, 8, 4);    wait_idle();
    send(21, 14, TO_CYC);               wait_idle();
    send(255, 17, 1);                   wait_idle();

    // Back-pressure: result held while out_ready low for 10 cycles.
    rdy_fix = 1'b0;
    send(25, 15, 2);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #2; n++; end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    repeat (10) @(posedge clk);
    #2;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    rdy_fix = 1'b1;
    wait_idle();

    // Reset in the middle of WAIT: the pair is dropped.
    send(25, 15, 0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_core_start", 32'(core_start), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_res", 32'(out_res), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_core_ab", 32'({core_a, core_b}), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    send(12, 9, 3);                     wait_idle();

    // Randomized traffic with random downstream back-pressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
      b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
      k = int'($urandom_range(0, TO_CYC));
      send(a, b, k);
    end
    rdy_rand = 1'b0;
    rdy_fix  = 1'b1;
    wait_idle();

    chk("core_start_count", 32'(starts), 32'(exp_starts));
`ifdef GCD_STATS_EN
    chk("stat_ops", 32'(stat_ops), 32'(hs_cnt));
    chk("stat_err", 32'(stat_err), 32'(to_cnt));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
